// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit: access codes,
// write-back constants, FSM states and access decode helpers.
package mem_lsu_pkg;

  localparam logic [3:0] MEM_NOP = 4'd0;
  localparam logic [3:0] MEM_LB  = 4'd1;
  localparam logic [3:0] MEM_LH  = 4'd2;
  localparam logic [3:0] MEM_LW  = 4'd3;
  localparam logic [3:0] MEM_LBU = 4'd4;
  localparam logic [3:0] MEM_LHU = 4'd5;
  localparam logic [3:0] MEM_SB  = 4'd6;
  localparam logic [3:0] MEM_SH  = 4'd7;
  localparam logic [3:0] MEM_SW  = 4'd8;

  localparam logic [4:0]  NOP_REG_ADDR = 5'd0;
  localparam logic [31:0] ZERO_WORD    = 32'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STORE
  } lsu_state_t;

  function automatic logic is_load(input logic [3:0] op);
    return (op >= MEM_LB) && (op <= MEM_LHU);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= MEM_SB) && (op <= MEM_SW);
  endfunction

  // Number of bytes moved by an access; only meaningful for load/store codes.
  function automatic logic [2:0] access_size(input logic [3:0] op);
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: return 3'd1;
      MEM_LH, MEM_LHU, MEM_SH: return 3'd2;
      default:                 return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_ext.sv
// Combinational extender: turns the little-endian assembled load bytes into
// the architectural register value for each load code.
module mem_lsu_ext
  import mem_lsu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] raw,
  output logic [31:0] ext
);

  always_comb begin
    ext = raw;
    case (op)
      MEM_LB:  ext = {{24{raw[7]}}, raw[7:0]};
      MEM_LBU: ext = {24'd0, raw[7:0]};
      MEM_LH:  ext = {{16{raw[15]}}, raw[15:0]};
      MEM_LHU: ext = {16'd0, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: runs each access as byte-serial transfers on
// an 8-bit RAM port, stalls upstream meanwhile and registers the write-back.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int RAM_AW = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        mem_wd,
  input  logic              mem_wreg,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_op,
  input  logic [31:0]       mem_sdata,
  input  logic [7:0]        ram_din,
  output logic [RAM_AW-1:0] ram_a,
  output logic [7:0]        ram_dout,
  output logic              ram_wr,
  output logic              stall_req,
  output logic [4:0]        wb_wd,
  output logic              wb_wreg,
  output logic [31:0]       wb_wdata
);

  lsu_state_t        state_reg, state_next;
  logic [2:0]        cnt_reg, cnt_next;
  logic [3:0]        op_reg;
  logic [31:0]       addr_reg;
  logic [31:0]       sdata_reg;
  logic [4:0]        wd_reg;
  logic              wreg_reg;
  logic [31:0]       data_reg, data_next;
  logic [31:0]       load_value;
  logic [2:0]        size;
  logic [2:0]        cap_idx;
  logic              cap_en;
  logic [RAM_AW-1:0] byte_addr;
  logic              acc_load, acc_store;

  assign acc_load  = is_load(mem_op);
  assign acc_store = is_store(mem_op);
  assign size      = access_size(op_reg);
  assign byte_addr = RAM_AW'(addr_reg + {29'd0, cnt_reg});

  // The byte addressed last cycle arrives now and lands in slot cnt-1.
  assign cap_en  = (state_reg == ST_LOAD) && (cnt_reg != 3'd0);
  assign cap_idx = cnt_reg - 3'd1;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      assign data_next[gi*8 +: 8] = (cap_en && (cap_idx == 3'(gi))) ? ram_din
                                                                     : data_reg[gi*8 +: 8];
    end
  endgenerate

  mem_lsu_ext u_ext (
    .op  (op_reg),
    .raw (data_next),
    .ext (load_value)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    stall_req  = 1'b0;
    ram_a      = '0;
    ram_dout   = 8'd0;
    ram_wr     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (acc_load) begin
          stall_req  = 1'b1;
          state_next = ST_LOAD;
          cnt_next   = 3'd0;
        end else if (acc_store) begin
          stall_req  = 1'b1;
          state_next = ST_STORE;
          cnt_next   = 3'd0;
        end
      end
      ST_LOAD: begin
        if (cnt_reg < size) begin
          stall_req = 1'b1;
          ram_a     = byte_addr;
          cnt_next  = cnt_reg + 3'd1;
        end else begin
          state_next = ST_IDLE;
          cnt_next   = 3'd0;
        end
      end
      ST_STORE: begin
        ram_a    = byte_addr;
        ram_dout = sdata_reg[8*cnt_reg[1:0] +: 8];
        ram_wr   = 1'b1;
        if (cnt_reg == size - 3'd1) begin
          state_next = ST_IDLE;
          cnt_next   = 3'd0;
        end else begin
          stall_req = 1'b1;
          cnt_next  = cnt_reg + 3'd1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 3'd0;
      op_reg    <= MEM_NOP;
      addr_reg  <= ZERO_WORD;
      sdata_reg <= ZERO_WORD;
      wd_reg    <= NOP_REG_ADDR;
      wreg_reg  <= 1'b0;
      data_reg  <= ZERO_WORD;
      wb_wd     <= NOP_REG_ADDR;
      wb_wreg   <= 1'b0;
      wb_wdata  <= ZERO_WORD;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      data_reg  <= data_next;
      case (state_reg)
        ST_IDLE: begin
          if (acc_load || acc_store) begin
            op_reg    <= mem_op;
            addr_reg  <= mem_wdata;
            sdata_reg <= mem_sdata;
            wd_reg    <= mem_wd;
            wreg_reg  <= mem_wreg;
            wb_wreg   <= 1'b0;
          end else begin
            wb_wd    <= mem_wd;
            wb_wreg  <= mem_wreg;
            wb_wdata <= mem_wdata;
          end
        end
        ST_LOAD: begin
          wb_wreg <= 1'b0;
          if (cnt_reg == size) begin
            wb_wd    <= wd_reg;
            wb_wreg  <= wreg_reg;
            wb_wdata <= load_value;
          end
        end
        default: wb_wreg <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed scenarios plus random accesses,
// compared against a byte-array memory model and arithmetic load/store rules.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  localparam int AW  = 17;
  localparam int MSZ = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [4:0]    mem_wd = '0;
  logic          mem_wreg = 1'b0;
  logic [31:0]   mem_wdata = '0;
  logic [3:0]    mem_op = '0;
  logic [31:0]   mem_sdata = '0;
  logic [7:0]    ram_din;
  logic [AW-1:0] ram_a;
  logic [7:0]    ram_dout;
  logic          ram_wr;
  logic          stall_req;
  logic [4:0]    wb_wd;
  logic          wb_wreg;
  logic [31:0]   wb_wdata;

  logic [7:0] ram     [MSZ];
  logic [7:0] ref_mem [MSZ];

  int total = 0;
  int bad   = 0;

  mem_lsu #(.RAM_AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_wd    (mem_wd),
    .mem_wreg  (mem_wreg),
    .mem_wdata (mem_wdata),
    .mem_op    (mem_op),
    .mem_sdata (mem_sdata),
    .ram_din   (ram_din),
    .ram_a     (ram_a),
    .ram_dout  (ram_dout),
    .ram_wr    (ram_wr),
    .stall_req (stall_req),
    .wb_wd     (wb_wd),
    .wb_wreg   (wb_wreg),
    .wb_wdata  (wb_wdata)
  );

  always #5 clk = ~clk;

  // Synchronous byte RAM: read data valid one cycle after its address.
  always @(posedge clk) begin
    if (ram_wr) ram[ram_a] <= ram_dout;
    ram_din <= ram[ram_a];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input int op);
    if (op == 1 || op == 4 || op == 6) return 1;
    if (op == 2 || op == 5 || op == 7) return 2;
    return 4;
  endfunction

  function automatic int mem_idx(input logic [31:0] addr, input int k);
    logic [31:0] a;
    a = addr + k;
    return int'(a % MSZ);
  endfunction

  function automatic logic [31:0] ref_load(input int op, input logic [31:0] addr);
    logic [31:0] v;
    v = 0;
    for (int k = 0; k < nbytes(op); k++)
      v = v + (32'(ref_mem[mem_idx(addr, k)]) << (8 * k));
    if (op == 1 && v >= 32'd128)   v = v + 32'hFFFF_FF00;
    if (op == 2 && v >= 32'd32768) v = v + 32'hFFFF_0000;
    return v;
  endfunction

  // Entered and left at a falling edge; drives one instruction and follows it
  // until it retires, checking RAM traffic, stall length and write-back.
  task automatic run_op(input string tag, input int op, input logic [4:0] wd, input logic wreg,
                        input logic [31:0] wdata, input logic [31:0] sdata);
    int          eop, n, stall_cnt, writes, exp_stall, exp_writes;
    bit          ld, st, done;
    logic [31:0] exp_load;
    eop = (op > 8) ? 0 : op;
    ld  = (eop >= 1 && eop <= 5);
    st  = (eop >= 6);
    n   = nbytes(eop);
    exp_load   = ld ? ref_load(eop, wdata) : 32'd0;
    exp_stall  = ld ? n + 1 : (st ? n : 0);
    exp_writes = st ? n : 0;
    stall_cnt = 0;
    writes    = 0;
    done      = 0;
    mem_op    = 4'(op);
    mem_wd    = wd;
    mem_wreg  = wreg;
    mem_wdata = wdata;
    mem_sdata = sdata;
    #1;
    for (int cyc = 0; cyc < 20 && !done; cyc++) begin
      if (stall_req === 1'b1) stall_cnt++;
      if (cyc >= 1) check($sformatf("%s bubble_c%0d", tag, cyc), 32'(wb_wreg), 32'd0);
      if (ld && cyc >= 1 && cyc <= n)
        check($sformatf("%s rd_addr%0d", tag, cyc - 1), 32'(ram_a), 32'(mem_idx(wdata, cyc - 1)));
      if (ram_wr === 1'b1) begin
        check($sformatf("%s wr_addr%0d", tag, writes), 32'(ram_a), 32'(mem_idx(wdata, writes)));
        check($sformatf("%s wr_data%0d", tag, writes), 32'(ram_dout), (sdata >> (8 * writes)) & 32'hFF);
        writes++;
      end
      if (stall_req === 1'b0) begin
        done = 1;
        @(posedge clk);
      end else begin
        @(posedge clk);
        @(negedge clk);
        #1;
      end
    end
    check({tag, " completed"}, 32'(done), 32'd1);
    @(negedge clk);
    check({tag, " stall_cycles"}, stall_cnt, exp_stall);
    check({tag, " write_count"}, writes, exp_writes);
    if (st) begin
      for (int k = 0; k < n; k++) ref_mem[mem_idx(wdata, k)] = 8'((sdata >> (8 * k)) & 32'hFF);
      for (int k = 0; k < n; k++)
        check($sformatf("%s mem%0d", tag, k), 32'(ram[mem_idx(wdata, k)]),
              32'(ref_mem[mem_idx(wdata, k)]));
      check({tag, " wb_wreg"}, 32'(wb_wreg), 32'd0);
    end else if (ld) begin
      check({tag, " wb_wdata"}, wb_wdata, exp_load);
      check({tag, " wb_wd"}, 32'(wb_wd), 32'(wd));
      check({tag, " wb_wreg"}, 32'(wb_wreg), 32'(wreg));
    end else begin
      check({tag, " wb_wdata"}, wb_wdata, wdata);
      check({tag, " wb_wd"}, 32'(wb_wd), 32'(wd));
      check({tag, " wb_wreg"}, 32'(wb_wreg), 32'(wreg));
    end
    $display("txn %s op=%0d addr=0x%08h sdata=0x%08h wb=0x%08h stalls=%0d", tag, op, wdata, sdata,
             wb_wdata, stall_cnt);
  endtask

  task automatic put_byte(input int idx, input logic [7:0] b);
    ram[idx]     = b;
    ref_mem[idx] = b;
  endtask

  initial begin
    logic [7:0] saved22;
    int         rop;
    logic [31:0] raddr;

    for (int i = 0; i < MSZ; i++) begin
      ram[i]     = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    put_byte(32'h100, 8'h78);
    put_byte(32'h101, 8'h56);
    put_byte(32'h102, 8'h34);
    put_byte(32'h103, 8'h12);
    put_byte(32'h7, 8'h80);
    put_byte(32'h8, 8'h00);
    put_byte(32'h9, 8'hFF);

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset wb_wd", 32'(wb_wd), 32'(NOP_REG_ADDR));
    check("reset wb_wreg", 32'(wb_wreg), 32'd0);
    check("reset wb_wdata", wb_wdata, 32'd0);
    check("reset ram_wr", 32'(ram_wr), 32'd0);
    check("reset ram_a", 32'(ram_a), 32'd0);
    check("reset ram_dout", 32'(ram_dout), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run_op("passthru", 0, 5'd3, 1'b1, 32'h0000_1234, 32'h0);

    // Abort a word load at cnt=2 with an asynchronous reset
    mem_op    = MEM_LW;
    mem_wd    = 5'd9;
    mem_wreg  = 1'b1;
    mem_wdata = 32'h100;
    repeat (3) @(posedge clk);
    #2;
    rst       = 1'b0;
    mem_op    = MEM_NOP;
    mem_wreg  = 1'b0;
    mem_wd    = 5'd0;
    mem_wdata = 32'h0;
    #1;
    check("midrst stall_req", 32'(stall_req), 32'd0);
    check("midrst ram_wr", 32'(ram_wr), 32'd0);
    check("midrst ram_a", 32'(ram_a), 32'd0);
    check("midrst wb_wreg", 32'(wb_wreg), 32'd0);
    check("midrst wb_wdata", wb_wdata, 32'd0);
    check("midrst wb_wd", 32'(wb_wd), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("postrst wb_wreg%0d", i), 32'(wb_wreg), 32'd0);
      check($sformatf("postrst stall%0d", i), 32'(stall_req), 32'd0);
    end
    @(negedge clk);

    run_op("lw_0x100", MEM_LW, 5'd4, 1'b1, 32'h100, 32'h0);
    run_op("lb_0x7", MEM_LB, 5'd5, 1'b1, 32'h7, 32'h0);
    run_op("lbu_0x7", MEM_LBU, 5'd6, 1'b1, 32'h7, 32'h0);
    run_op("lh_0x8", MEM_LH, 5'd7, 1'b1, 32'h8, 32'h0);
    check("lh_0x8 literal", wb_wdata, 32'hFFFF_FF00);
    saved22 = ram[32'h22];
    run_op("sh_0x20", MEM_SH, 5'd8, 1'b1, 32'h20, 32'hAABB_CCDD);
    check("sh_0x20 untouched", 32'(ram[32'h22]), 32'(saved22));
    run_op("sw_0x40", MEM_SW, 5'd0, 1'b0, 32'h40, 32'hCAFE_F00D);
    run_op("lw_0x40", MEM_LW, 5'd10, 1'b1, 32'h40, 32'h0);
    check("sw_lw literal", wb_wdata, 32'hCAFE_F00D);
    run_op("lhu_wrap", MEM_LHU, 5'd11, 1'b1, 32'hFFFF_FFFF, 32'h0);
    run_op("op_13_nop", 13, 5'd12, 1'b1, 32'hDEAD_BEEF, 32'h0);

    for (int t = 0; t < 150; t++) begin
      rop   = $urandom_range(0, 15);
      raddr = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 63)) : $urandom;
      run_op($sformatf("rnd%0d", t), rop, 5'($urandom), 1'($urandom), raddr, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Memory-stage load/store unit and the consumer of the EX/MEM pipeline register outputs.
- Takes the latched access descriptor and runs it as byte-serial transfers over the 8-bit RAM port.
- Returns the write-back triple to MEM/WB.
- Asserts stall_req toward the stall controller, which issues the halt_type that freezes the upstream pipeline registers until the access completes.

Parameters:
- RAM_AW, 17, width of the RAM byte address port (mem_a = addr[RAM_AW-1:0]).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- mem_wd  in  5  destination register from EX/MEM
- mem_wreg  in  1  register write enable from EX/MEM
- mem_wdata  in  32  ALU result, or effective address for loads/stores
- mem_op  in  4  access code; define.v MemNop/LB/LH/LW/LBU/LHU/SB/SH/SW = 0..8
- mem_sdata  in  32  store data
- ram_din  in  8  RAM read byte, valid one cycle after its address
- ram_a  out  RAM_AW  RAM byte address
- ram_dout  out  8  RAM write byte
- ram_wr  out  1  RAM write strobe
- stall_req  out  1  hold upstream stages (combinational)
- wb_wd  out  5  registered write-back destination
- wb_wreg  out  1  registered write-back enable
- wb_wdata  out  32  registered write-back data

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, cnt=0.
  - wb_wd=NOPRegAddr, wb_wreg=0, wb_wdata=0.
  - ram_wr=0, ram_a=0, ram_dout=0.
  - Reset mid-access aborts the access; no write-back is produced.
- Codes 9..15 are treated as MemNop.
- Access size N: 1 for B/BU, 2 for H/HU, 4 for W. Little-endian; byte k is at addr+k (32-bit wrap, then truncated). No alignment check.
- IDLE, mem_op=MemNop:
  - No stall.
  - Next edge: wb_* <= mem_wd/mem_wreg/mem_wdata (1-cycle latency).
- IDLE, mem_op load/store:
  - stall_req=1.
  - Next edge: latch op, addr, sdata, wd, wreg; cnt=0; enter LOAD or STORE; wb_wreg <= 0.
  - RAM outputs stay idle in this cycle.
- LOAD (cnt=c, 0..N):
  - For c<N: ram_a=addr+c, ram_wr=0.
  - For c>=1: at the edge, capture ram_din into byte c-1.
  - stall_req=1 while c<N; stall_req=0 at c=N.
  - At the edge with c=N:
    - wb_wd=latched wd, wb_wreg=latched wreg.
    - wb_wdata=assembled value: sign-extended for LB/LH, zero-extended for LBU/LHU.
    - Return to IDLE.
  - Load latency: N+2 cycles from acceptance to wb valid.
- STORE (cnt=c, 0..N-1):
  - ram_a=addr+c, ram_dout=sdata byte c, ram_wr=1.
  - stall_req=0 at c=N-1.
  - At the edge with c=N-1: wb_wreg <= 0, return to IDLE.
- During LOAD/STORE, wb_wreg=0 every cycle (bubble); the unit has no write-back except on completion.
- mem_* inputs are ignored after latching. The stall controller keeps them stable anyway.
- The instruction arriving in the cycle after completion is evaluated in IDLE as normal (back-to-back accesses allowed).
- ram_* are combinational from state/cnt/latched regs. They are idle (ram_wr=0) in IDLE.

Decomposition:
- Mem op codes MemNop..SW, NOPRegAddr and ZeroWord go in define.v.
- Optional sub-module mem_lsu_ext: combinational byte/half sign/zero extender.
- The FSM, counter and byte assembly stay in mem_lsu.

Test Plan:
- Reset mid-LW (rst low at cnt=2) -> all outputs zero, state IDLE, no wb_wreg pulse after rst rises.
- ALU pass-through: mem_op=0, wd=3, wreg=1, wdata=0x1234 -> next cycle wb_wd=3, wb_wreg=1, wb_wdata=0x1234; stall_req never 1.
- LW at 0x100 with RAM 0x100..0x103 = 78 56 34 12:
  - ram_a=0x100..0x103 on consecutive cycles.
  - stall_req high 5 cycles.
  - Then wb_wdata=0x12345678.
- LB/LBU at 0x7 holding 0x80 -> LB gives 0xFFFFFF80; LBU gives 0x00000080. LH at 0x8 holding 00 FF -> 0xFFFFFF00.
- SH at 0x20 with sdata=0xAABBCCDD -> ram_wr=1 two cycles: (0x20,0xDD), (0x21,0xCC); wb_wreg stays 0; memory 0x22 untouched.
- SW then immediate LW of the same address -> load returns the stored word with no idle cycle between the two accesses.
